// File: rtl/cs_resolver.sv
// cs_resolver: serial carry-propagate resolver for a carry-save pair.
// Resolves CHUNK bits per clock, LSB first, reusing one narrow adder
// across K = WIDTH/CHUNK cycles. Valid/ready handshakes on both sides.

// Narrow CHUNK-bit adder reused on every BUSY cycle.
module cs_chunk_add #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co
);
   // One extra bit on the operands captures the chunk carry-out.
   always_comb begin
      {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
   end
endmodule

module cs_resolver #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] ps,
   input  logic [WIDTH-1:0] pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int K  = WIDTH / CHUNK;
   localparam int IW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] ps_r, pc_r, sum_r;
   logic             carry, cout_r;
   logic [IW-1:0]    idx;
   logic             accept, last;
   logic [WIDTH-1:0] ps_sh, pc_sh;
   logic [CHUNK-1:0] s_ch;
   logic             c_ch;

   assign accept = (state == IDLE) && in_valid;
   assign last   = (idx == IW'(K - 1));

   // Align the active chunk to the LSBs; a shift keeps K == 1 free of
   // zero-width index corner cases.
   assign ps_sh = ps_r >> (CHUNK * idx);
   assign pc_sh = pc_r >> (CHUNK * idx);

   cs_chunk_add #(.CHUNK(CHUNK)) u_add (
      .a  (ps_sh[CHUNK-1:0]),
      .b  (pc_sh[CHUNK-1:0]),
      .ci (carry),
      .s  (s_ch),
      .co (c_ch)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic: no accept from DONE, even with in_valid high.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = BUSY;
         BUSY:    if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded purely from registered state.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Datapath: capture on accept, then ripple one chunk per BUSY cycle.
   // Unresolved sum chunks keep their old contents until overwritten.
   always_ff @(posedge clk) begin
      if (rst) begin
         ps_r   <= '0;
         pc_r   <= '0;
         sum_r  <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         idx    <= '0;
      end else if (accept) begin
         ps_r  <= ps;
         pc_r  <= pc;
         carry <= 1'b0;
         idx   <= '0;
      end else if (state == BUSY) begin
         for (int j = 0; j < K; j++)
            if (idx == IW'(j)) sum_r[j*CHUNK +: CHUNK] <= s_ch;
         carry <= c_ch;
         if (last) cout_r <= c_ch;
         else      idx    <= idx + IW'(1);
      end
   end

   assign sum  = sum_r;
   assign cout = cout_r;
endmodule

// File: tb/tb_cs_resolver.sv
// tb_cs_resolver: directed checks of cs_resolver in the 16/4 configuration
// and the degenerate 16/16 configuration.
module tb_cs_resolver;
   localparam int W = 16;
   localparam int C = 4;
   localparam int K = W / C;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         a_iv, a_ir, a_ov, a_or, a_co;
   logic [W-1:0] a_ps, a_pc, a_sum;
   logic         b_iv, b_ir, b_ov, b_or, b_co;
   logic [W-1:0] b_ps, b_pc, b_sum;

   int n_chk  = 0;
   int n_fail = 0;

   cs_resolver #(.WIDTH(W), .CHUNK(C)) u_a (
      .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir),
      .ps(a_ps), .pc(a_pc), .out_valid(a_ov), .out_ready(a_or),
      .sum(a_sum), .cout(a_co)
   );

   cs_resolver #(.WIDTH(W), .CHUNK(W)) u_b (
      .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir),
      .ps(b_ps), .pc(b_pc), .out_valid(b_ov), .out_ready(b_or),
      .sum(b_sum), .cout(b_co)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // All driving and sampling happens on the falling edge.
   task automatic tick;
      @(negedge clk);
   endtask

   // One complete operation on the 16/4 instance with hand-computed result.
   task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] exp_s, input logic exp_c);
      int lat;
      a_ps = x; a_pc = y; a_iv = 1'b1;
      tick;
      a_iv = 1'b0;
      check({tag, ".busy_rdy"}, 32'(a_ir), 32'd0);
      lat = 0;
      while (!a_ov && lat < 20) begin
         tick;
         lat++;
      end
      check({tag, ".lat"},  lat,          K);
      check({tag, ".sum"},  32'(a_sum),   32'(exp_s));
      check({tag, ".cout"}, 32'(a_co),    32'(exp_c));
      check({tag, ".drdy"}, 32'(a_ir),    32'd0);
      a_or = 1'b1;
      tick;
      a_or = 1'b0;
      check({tag, ".idle_rdy"}, 32'(a_ir), 32'd1);
      check({tag, ".idle_ov"},  32'(a_ov), 32'd0);
   endtask

   logic [W-1:0] tp [5] = '{16'h0000, 16'hFFFF, 16'h8001, 16'h7FFF, 16'hA5A5};
   logic [W-1:0] tq [5] = '{16'h0000, 16'h0000, 16'h7FFF, 16'h0001, 16'h5A5B};
   logic [W:0]   expq [$];

   initial begin
      int lat, n, got, last_acc;
      logic [W:0] r;
      rst = 1'b1;
      a_iv = 0; a_or = 0; a_ps = '0; a_pc = '0;
      b_iv = 0; b_or = 0; b_ps = '0; b_pc = '0;
      tick; tick;
      check("rst.ir",   32'(a_ir),  32'd1);
      check("rst.ov",   32'(a_ov),  32'd0);
      check("rst.sum",  32'(a_sum), 32'd0);
      check("rst.cout", 32'(a_co),  32'd0);
      rst = 1'b0;
      tick;
      check("post_rst.ir", 32'(a_ir), 32'd1);

      run_op("basic",  16'h1234, 16'h0F0F, 16'h2143, 1'b0);
      run_op("ripple", 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
      run_op("ovf",    16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1);

      // Backpressure plus input isolation: inputs move after accept.
      a_ps = 16'h1111; a_pc = 16'h2222; a_iv = 1'b1;
      tick;
      a_ps = 16'hAAAA; a_pc = 16'h5555;
      lat = 0;
      while (!a_ov && lat < 20) begin
         tick;
         lat++;
      end
      check("iso.lat", lat, K);
      for (int i = 0; i < 10; i++) begin
         check("hold.res", 32'({a_ov, a_co, a_sum}), {14'd0, 1'b1, 1'b0, 16'h3333});
         check("hold.ir",  32'(a_ir), 32'd0);
         tick;
      end
      a_or = 1'b1;
      tick;
      check("done_noacc.ir", 32'(a_ir), 32'd1);
      check("done_noacc.ov", 32'(a_ov), 32'd0);
      a_iv = 1'b0; a_or = 1'b0;
      tick;
      check("idle_stay.ir", 32'(a_ir), 32'd1);

      // Reset while BUSY with idx == 2.
      a_ps = 16'hFFFF; a_pc = 16'h0001; a_iv = 1'b1;
      tick;
      a_iv = 1'b0;
      tick; tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("mrst.ov",   32'(a_ov),  32'd0);
      check("mrst.sum",  32'(a_sum), 32'd0);
      check("mrst.cout", 32'(a_co),  32'd0);
      check("mrst.ir",   32'(a_ir),  32'd1);
      for (int i = 0; i < 6; i++) begin
         tick;
         check("mrst.no_ov", 32'(a_ov), 32'd0);
      end
      run_op("after_rst", 16'h0001, 16'h0001, 16'h0002, 1'b0);

      // Back-to-back with out_ready tied high and in_valid held high.
      a_or = 1'b1; a_iv = 1'b1;
      n = 0; got = 0; last_acc = -1;
      for (int cyc = 0; cyc < 200 && got < 5; cyc++) begin
         if (a_ov) begin
            r = (expq.size() > 0) ? expq.pop_front() : '0;
            check("b2b.sum",  32'(a_sum), 32'(r[W-1:0]));
            check("b2b.cout", 32'(a_co),  32'(r[W]));
            got++;
         end
         if (a_ir) begin
            if (n < 5) begin
               a_ps = tp[n]; a_pc = tq[n];
               expq.push_back({1'b0, tp[n]} + {1'b0, tq[n]});
               if (last_acc >= 0) check("b2b.space", cyc - last_acc, K + 2);
               last_acc = cyc;
               n++;
            end else begin
               a_iv = 1'b0;
            end
         end
         tick;
      end
      check("b2b.count", got, 5);
      a_iv = 1'b0; a_or = 1'b0;

      // Degenerate single-chunk configuration.
      b_ps = 16'h8000; b_pc = 16'h8000; b_iv = 1'b1;
      tick;
      b_iv = 1'b0;
      check("deg.busy_ov", 32'(b_ov), 32'd0);
      check("deg.busy_ir", 32'(b_ir), 32'd0);
      tick;
      check("deg.ov",   32'(b_ov),  32'd1);
      check("deg.sum",  32'(b_sum), 32'd0);
      check("deg.cout", 32'(b_co),  32'd1);
      b_or = 1'b1;
      tick;
      b_or = 1'b0;
      check("deg.idle", 32'(b_ir), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
